nic_out_queue: RTL and testbench
================================

Name: nic_out_queue

Overview:
- Multi-slot NIC output stage. Holds up to N_SLOTS complete packets.
- Each slot independently requests VC allocation, then transmits its flits.
- A round-robin link arbiter picks one slot per flit, gated by per-VC credits.
- Sits between the NIC packetiser and the router injection port.

Parameters:
FLIT_WIDTH, 64, flit width in bits
MAX_PKT_FLITS, 4, maximum flits per packet (slot depth)
LEN_W, 3, width of pkt_len_i; must hold MAX_PKT_FLITS
N_SLOTS, 4, packet slots
N_VC, 4, downstream VCs, one-hot encoded
VC_IDX_W, 2, clog2(N_VC)
VNET_W, 2, vnet id width (unsigned)
MAX_CREDIT, 4, per-VC downstream buffer depth
CRED_W, 3, credit counter width; must hold MAX_CREDIT
VC_FIELD_LSB, 56, LSB of the VC-index field inside each flit

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pkt_i  in  MAX_PKT_FLITS*FLIT_WIDTH  packet; flit k at [(k+1)*FLIT_WIDTH-1:k*FLIT_WIDTH]
pkt_len_i  in  LEN_W  flit count, 1..MAX_PKT_FLITS
vnet_id_i  in  VNET_W  packet vnet
pkt_valid_i  in  1  packet offered
pkt_ready_o  out  1  at least one slot IDLE
va_req_o  out  N_SLOTS  per-slot VA request
va_vnet_o  out  N_SLOTS*VNET_W  per-slot vnet
va_grant_i  in  N_SLOTS  per-slot VA grant, at most one bit per cycle
va_vc_i  in  N_VC  one-hot VC, valid with va_grant_i
link_req_o  out  1  any slot eligible
link_grant_i  in  1  link granted this cycle
flit_o  out  FLIT_WIDTH  registered flit
flit_valid_o  out  1  flit_o valid
credit_in_i  in  N_VC  per-VC credit return; several bits may be set
release_o  out  N_VC  one-cycle pulse: VC freed (tail sent)
free_slots_o  out  clog2(N_SLOTS+1)  count of IDLE slots
credit_err_o  out  1  see Optional Feature

Behaviour:
- Reset: all slots IDLE; va_req_o=0, link_req_o=0, flit_valid_o=0, flit_o=0, release_o=0, credit_err_o=0.
- Reset: all credit counters=MAX_CREDIT; RR pointer=N_SLOTS-1, so slot 0 has first priority. Reset mid-packet discards all slots.
- Accept: pkt_valid_i && pkt_ready_o loads the lowest-index IDLE slot with pkt_i, pkt_len_i, vnet_id_i. Flit pointer=0, state VA_REQ next cycle.
- Free-slot view: pkt_ready_o and free_slots_o are computed from registered state. A slot leaving XMIT is not reusable until the following cycle.
- Slot FSM IDLE -> VA_REQ -> XMIT -> IDLE.
- VA_REQ: va_req_o[s]=1. On va_grant_i[s], store va_vc_i and go to XMIT. A grant to a non-VA_REQ slot is ignored.
- XMIT eligibility: slot is eligible iff credit[vc]>0. link_req_o = OR of eligible slots.
- Arbitration is combinational round-robin, searching from RR pointer+1. The pointer updates to the winner only on link_grant_i.
- On link_grant_i with a winner:
  - Next cycle: flit_o = slot flit[ptr] with bits [VC_FIELD_LSB+VC_IDX_W-1:VC_FIELD_LSB] replaced by the binary index of the slot VC; flit_valid_o=1.
  - Slot ptr increments and credit[vc] decrements.
  - Latency grant -> flit_valid_o is exactly 1 cycle. flit_valid_o=0 in any cycle without a preceding grant.
- Last flit: when granted ptr==pkt_len-1, the slot returns to IDLE next cycle. release_o[vc] pulses in the same cycle as that flit's flit_valid_o. Single-flit packets follow the same rule.
- Credits, per VC:
  - +1 on credit_in_i[v]; -1 on a grant for VC v; both in the same cycle -> unchanged.
  - Counter at 0 makes slots on that VC ineligible until a credit returns. A credit returned in the same cycle as the counter reaches 0 is eligible next cycle.
- Flits of different slots (different VCs) may interleave on the link. The order within one slot is strictly 0..len-1.
- pkt_len_i=0 or >MAX_PKT_FLITS is illegal; behaviour is undefined.

Optional Feature:
- Macro NIC_OUTQ_CREDIT_CHECK_EN.
- Defined: credit_err_o is sticky high, cleared only by rst, on any of:
  - a credit return that would exceed MAX_CREDIT (counter saturates at MAX_CREDIT);
  - link_grant_i while link_req_o=0;
  - va_grant_i with more than one bit set.
- Not defined: credit_err_o is tied 0, there is no saturation logic, and out-of-range credits wrap modulo 2^CRED_W.

Test Plan:
- Single 1-flit packet, vnet 1 -> va_req_o[0]; grant with VC 0010 -> link_req_o; grant -> next cycle flit_valid_o=1, VC field=1, release_o=0010, free_slots_o back to 4.
- 4-flit packet on VC 0001, no credit returns -> exactly 4 flits sent, link_req_o=0 afterwards; one credit_in_i[0] after the tail -> counter=1.
- Two slots in XMIT (VC0, VC1), link_grant_i held high -> flits alternate slot0, slot1, slot0, slot1; each stream is in order.
- Four packets accepted back-to-back -> slots 0..3 filled, pkt_ready_o=0; fifth packet held until a tail completes, then loaded into the freed slot one cycle later.
- Credit at 1 with credit return and grant in the same cycle -> counter stays 1, no stall; rst asserted mid-packet -> all outputs 0, credits=4 next cycle.
- With NIC_OUTQ_CREDIT_CHECK_EN: credit_in_i[2] pulsed while credit[2]=4 -> credit_err_o=1 and stays high, counter remains 4.

Source files
------------

// File: rtl/nic_out_queue.sv
// nic_out_queue: multi-slot NIC output stage between the packetiser and the
// router injection port. Each slot holds one whole packet, requests a VC and
// then competes for the link through a credit-gated round-robin arbiter.
// Optional build macro: NIC_OUTQ_CREDIT_CHECK_EN enables the sticky
// credit_err_o protocol checker and saturating credit counters.
module nic_out_queue #(
    parameter int FLIT_WIDTH    = 64,
    parameter int MAX_PKT_FLITS = 4,
    parameter int LEN_W         = 3,
    parameter int N_SLOTS       = 4,
    parameter int N_VC          = 4,
    parameter int VC_IDX_W      = 2,
    parameter int VNET_W        = 2,
    parameter int MAX_CREDIT    = 4,
    parameter int CRED_W        = 3,
    parameter int VC_FIELD_LSB  = 56
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [MAX_PKT_FLITS*FLIT_WIDTH-1:0] pkt_i,
    input  logic [LEN_W-1:0]                    pkt_len_i,
    input  logic [VNET_W-1:0]                   vnet_id_i,
    input  logic                                pkt_valid_i,
    output logic                                pkt_ready_o,
    output logic [N_SLOTS-1:0]                  va_req_o,
    output logic [N_SLOTS*VNET_W-1:0]           va_vnet_o,
    input  logic [N_SLOTS-1:0]                  va_grant_i,
    input  logic [N_VC-1:0]                     va_vc_i,
    output logic                                link_req_o,
    input  logic                                link_grant_i,
    output logic [FLIT_WIDTH-1:0]               flit_o,
    output logic                                flit_valid_o,
    input  logic [N_VC-1:0]                     credit_in_i,
    output logic [N_VC-1:0]                     release_o,
    output logic [$clog2(N_SLOTS+1)-1:0]        free_slots_o,
    output logic                                credit_err_o
);

    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int FREE_W = $clog2(N_SLOTS + 1);

    typedef enum logic [1:0] {IDLE, VA_REQ, XMIT} slot_state_t;

    slot_state_t                          state      [N_SLOTS];
    slot_state_t                          next_state [N_SLOTS];
    logic [MAX_PKT_FLITS*FLIT_WIDTH-1:0]  data       [N_SLOTS];
    logic [LEN_W-1:0]                     len        [N_SLOTS];
    logic [LEN_W-1:0]                     ptr        [N_SLOTS];
    logic [VNET_W-1:0]                    vnet       [N_SLOTS];
    logic [VC_IDX_W-1:0]                  vc         [N_SLOTS];
    logic [CRED_W-1:0]                    credit      [N_VC];
    logic [CRED_W-1:0]                    credit_next [N_VC];

    logic [N_SLOTS-1:0]    eligible;
    logic [N_VC-1:0]       consume;
    logic [SLOT_W-1:0]     rr_ptr;
    logic [SLOT_W-1:0]     winner;
    logic [SLOT_W-1:0]     cand;
    logic [SLOT_W-1:0]     load_sel;
    logic [VC_IDX_W-1:0]   va_idx;
    logic [FREE_W-1:0]     free_cnt;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  any_eligible;
    logic                  fire;
    logic                  load;
    logic                  win_last;

    // Slot occupancy view from registered state: lowest IDLE slot and free count
    always_comb begin
        load_sel    = '0;
        free_cnt    = '0;
        pkt_ready_o = 1'b0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (state[s] == IDLE) begin
                load_sel    = SLOT_W'(s);
                free_cnt    = free_cnt + FREE_W'(1);
                pkt_ready_o = 1'b1;
            end
        end
    end

    assign free_slots_o = free_cnt;
    assign load         = pkt_valid_i && pkt_ready_o;

    // Per-slot VA request, vnet view and link eligibility (needs a credit on its VC)
    always_comb begin
        va_req_o  = '0;
        va_vnet_o = '0;
        eligible  = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            va_req_o[s]                   = (state[s] == VA_REQ);
            va_vnet_o[s*VNET_W +: VNET_W] = vnet[s];
            eligible[s]                   = (state[s] == XMIT) && (credit[vc[s]] != '0);
        end
    end

    // Round-robin search starting one past the last winner
    always_comb begin
        winner       = rr_ptr;
        cand         = '0;
        any_eligible = 1'b0;
        for (int i = 1; i <= N_SLOTS; i++) begin
            cand = SLOT_W'((int'(rr_ptr) + i) % N_SLOTS);
            if (!any_eligible && eligible[cand]) begin
                winner       = cand;
                any_eligible = 1'b1;
            end
        end
    end

    assign link_req_o = any_eligible;
    assign fire       = link_grant_i && any_eligible;
    assign win_last   = (ptr[winner] == len[winner] - LEN_W'(1));

    // Winning flit with its VC-index field overwritten by the allocated VC
    always_comb begin
        out_flit = data[winner][int'(ptr[winner])*FLIT_WIDTH +: FLIT_WIDTH];
        out_flit[VC_FIELD_LSB +: VC_IDX_W] = vc[winner];
    end

    // Binary index of the one-hot VC handed out by the allocator
    always_comb begin
        va_idx = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (va_vc_i[v]) begin
                va_idx = VC_IDX_W'(v);
            end
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        for (int s = 0; s < N_SLOTS; s++) begin
            state[s] <= rst ? IDLE : next_state[s];
        end
    end

    // Slot FSM transitions: load, VC grant, tail flit granted
    always_comb begin
        for (int s = 0; s < N_SLOTS; s++) begin
            next_state[s] = state[s];
            case (state[s])
                IDLE:    if (load && load_sel == SLOT_W'(s)) next_state[s] = VA_REQ;
                VA_REQ:  if (va_grant_i[s]) next_state[s] = XMIT;
                XMIT:    if (fire && winner == SLOT_W'(s) && win_last) next_state[s] = IDLE;
                default: next_state[s] = IDLE;
            endcase
        end
    end

    // Slot payload, VC capture and flit pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                data[s] <= '0;
                len[s]  <= '0;
                ptr[s]  <= '0;
                vnet[s] <= '0;
                vc[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (load && load_sel == SLOT_W'(s)) begin
                    data[s] <= pkt_i;
                    len[s]  <= pkt_len_i;
                    vnet[s] <= vnet_id_i;
                    ptr[s]  <= '0;
                end
                if (state[s] == VA_REQ && va_grant_i[s]) begin
                    vc[s] <= va_idx;
                end
            end
            if (fire) begin
                ptr[winner] <= ptr[winner] + LEN_W'(1);
            end
        end
    end

    // Credit arithmetic: return and consume in one cycle cancel out
    always_comb begin
        consume = '0;
        for (int v = 0; v < N_VC; v++) begin
            credit_next[v] = credit[v];
            consume[v]     = fire && (vc[winner] == VC_IDX_W'(v));
            if (credit_in_i[v] && !consume[v]) begin
`ifdef NIC_OUTQ_CREDIT_CHECK_EN
                if (credit[v] != CRED_W'(MAX_CREDIT)) begin
                    credit_next[v] = credit[v] + CRED_W'(1);
                end
`else
                credit_next[v] = credit[v] + CRED_W'(1);
`endif
            end else if (!credit_in_i[v] && consume[v]) begin
                credit_next[v] = credit[v] - CRED_W'(1);
            end
        end
    end

    // Credit counters start full
    always_ff @(posedge clk) begin
        for (int v = 0; v < N_VC; v++) begin
            credit[v] <= rst ? CRED_W'(MAX_CREDIT) : credit_next[v];
        end
    end

    // Registered link output, tail release pulse and arbiter pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
            release_o    <= '0;
            rr_ptr       <= SLOT_W'(N_SLOTS - 1);
        end else begin
            flit_valid_o <= fire;
            release_o    <= (fire && win_last) ? (N_VC'(1) << vc[winner]) : '0;
            if (fire) begin
                flit_o <= out_flit;
                rr_ptr <= winner;
            end
        end
    end

`ifdef NIC_OUTQ_CREDIT_CHECK_EN
    logic [N_VC-1:0] at_max;

    // Counters already full, so an uncancelled return would overflow
    always_comb begin
        at_max = '0;
        for (int v = 0; v < N_VC; v++) begin
            at_max[v] = (credit[v] == CRED_W'(MAX_CREDIT));
        end
    end

    // Sticky protocol error: credit overflow, grant without request, multi-hot VA grant
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_o <= 1'b0;
        end else if ((|(credit_in_i & ~consume & at_max)) ||
                     (link_grant_i && !any_eligible) ||
                     ((va_grant_i & (va_grant_i - N_SLOTS'(1))) != '0)) begin
            credit_err_o <= 1'b1;
        end
    end
`else
    assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nic_out_queue.sv
// tb_nic_out_queue: directed scenarios plus randomized traffic for
// nic_out_queue, compared every cycle against a behavioural model of slots,
// credits and round-robin link arbitration kept inside the bench.
module tb_nic_out_queue;

    localparam int FLIT_WIDTH    = 64;
    localparam int MAX_PKT_FLITS = 4;
    localparam int N_SLOTS       = 4;
    localparam int N_VC          = 4;
    localparam int VC_IDX_W      = 2;
    localparam int MAX_CREDIT    = 4;
    localparam int VC_FIELD_LSB  = 56;

    logic         clk;
    logic         rst;
    logic [255:0] pkt_i;
    logic [2:0]   pkt_len_i;
    logic [1:0]   vnet_id_i;
    logic         pkt_valid_i;
    logic         pkt_ready_o;
    logic [3:0]   va_req_o;
    logic [7:0]   va_vnet_o;
    logic [3:0]   va_grant_i;
    logic [3:0]   va_vc_i;
    logic         link_req_o;
    logic         link_grant_i;
    logic [63:0]  flit_o;
    logic         flit_valid_o;
    logic [3:0]   credit_in_i;
    logic [3:0]   release_o;
    logic [2:0]   free_slots_o;
    logic         credit_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: 0 = empty, 1 = waiting for VC, 2 = sending
    int          m_state [N_SLOTS];
    logic [63:0] m_flit  [N_SLOTS][MAX_PKT_FLITS];
    int          m_len   [N_SLOTS];
    int          m_sent  [N_SLOTS];
    int          m_vnet  [N_SLOTS];
    int          m_vc    [N_SLOTS];
    int          m_cred  [N_VC];
    int          m_rr;
    bit          m_fv;
    logic [63:0] m_fo;
    logic [3:0]  m_rel;
    bit          m_err;
    bit          m_rst_seen;

    nic_out_queue dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_i        (pkt_i),
        .pkt_len_i    (pkt_len_i),
        .vnet_id_i    (vnet_id_i),
        .pkt_valid_i  (pkt_valid_i),
        .pkt_ready_o  (pkt_ready_o),
        .va_req_o     (va_req_o),
        .va_vnet_o    (va_vnet_o),
        .va_grant_i   (va_grant_i),
        .va_vc_i      (va_vc_i),
        .link_req_o   (link_req_o),
        .link_grant_i (link_grant_i),
        .flit_o       (flit_o),
        .flit_valid_o (flit_valid_o),
        .credit_in_i  (credit_in_i),
        .release_o    (release_o),
        .free_slots_o (free_slots_o),
        .credit_err_o (credit_err_o)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // First sending slot with credit, searching one past the last winner
    function automatic int modelWinner();
        int s;
        for (int k = 1; k <= N_SLOTS; k++) begin
            s = (m_rr + k) % N_SLOTS;
            if (m_state[s] == 2 && m_cred[m_vc[s]] > 0) return s;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic modelStep();
        int  w;
        int  acc;
        int  c;
        bit  fire;
        if (rst) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                m_state[s] = 0;
                m_sent[s]  = 0;
            end
            for (int v = 0; v < N_VC; v++) m_cred[v] = MAX_CREDIT;
            m_rr = N_SLOTS - 1;
            m_fv = 1'b0;
            m_fo = '0;
            m_rel = '0;
            m_err = 1'b0;
            m_rst_seen = 1'b1;
            return;
        end
        m_rst_seen = 1'b0;
        w = modelWinner();
        fire = link_grant_i && (w >= 0);
        acc = -1;
        for (int s = N_SLOTS - 1; s >= 0; s--) if (m_state[s] == 0) acc = s;
`ifdef NIC_OUTQ_CREDIT_CHECK_EN
        if (link_grant_i && w < 0) m_err = 1'b1;
        if ($countones(va_grant_i) > 1) m_err = 1'b1;
`endif
        for (int v = 0; v < N_VC; v++) begin
            c = m_cred[v] + int'(credit_in_i[v]);
            if (fire) begin
                if (m_vc[w] == v) c = c - 1;
            end
`ifdef NIC_OUTQ_CREDIT_CHECK_EN
            if (c > MAX_CREDIT) begin
                c = MAX_CREDIT;
                m_err = 1'b1;
            end
`endif
            m_cred[v] = c;
        end
        m_fv  = fire;
        m_rel = '0;
        if (fire) begin
            m_fo = m_flit[w][m_sent[w]];
            m_fo[VC_FIELD_LSB +: VC_IDX_W] = 2'(m_vc[w]);
            m_sent[w]++;
            m_rr = w;
            if (m_sent[w] == m_len[w]) begin
                m_state[w] = 0;
                m_rel = 4'(1 << m_vc[w]);
            end
        end
        for (int s = 0; s < N_SLOTS; s++) begin
            if (va_grant_i[s] && m_state[s] == 1) begin
                m_state[s] = 2;
                for (int v = 0; v < N_VC; v++) if (va_vc_i[v]) m_vc[s] = v;
            end
        end
        if (pkt_valid_i && acc >= 0) begin
            m_state[acc] = 1;
            m_len[acc]   = int'(pkt_len_i);
            m_vnet[acc]  = int'(vnet_id_i);
            m_sent[acc]  = 0;
            for (int k = 0; k < MAX_PKT_FLITS; k++) m_flit[acc][k] = pkt_i[k*64 +: 64];
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        int         nfree;
        logic [3:0] exp_va;
        nfree  = 0;
        exp_va = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (m_state[s] == 0) nfree++;
            if (m_state[s] == 1) begin
                exp_va[s] = 1'b1;
                check("va_vnet", 64'(va_vnet_o[s*2 +: 2]), 64'(m_vnet[s]));
            end
        end
        check("pkt_ready", 64'(pkt_ready_o), 64'(nfree > 0));
        check("free_slots", 64'(free_slots_o), 64'(nfree));
        check("va_req", 64'(va_req_o), 64'(exp_va));
        check("link_req", 64'(link_req_o), 64'(modelWinner() >= 0));
        check("flit_valid", 64'(flit_valid_o), 64'(m_fv));
        if (m_fv || m_rst_seen) check("flit", flit_o, m_fo);
        check("release", 64'(release_o), 64'(m_rel));
        check("credit_err", 64'(credit_err_o), 64'(m_err));
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearInputs();
        pkt_valid_i  = 1'b0;
        va_grant_i   = '0;
        link_grant_i = 1'b0;
        credit_in_i  = '0;
        rst          = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Flit k of a packet carries tag*16+k in its low byte
    task automatic setPkt(input int len, input int vnet, input int tag);
        for (int k = 0; k < MAX_PKT_FLITS; k++) begin
            pkt_i[k*64 +: 64] = {$urandom, $urandom};
            pkt_i[k*64 +: 8]  = 8'(tag * 16 + k);
        end
        pkt_len_i = 3'(len);
        vnet_id_i = 2'(vnet);
    endtask

    task automatic loadPkt(input int len, input int vnet, input int tag);
        setPkt(len, vnet, tag);
        pkt_valid_i = 1'b1;
        tick();
        pkt_valid_i = 1'b0;
    endtask

    task automatic vaGrant(input int slot, input int vc);
        va_grant_i = 4'(1 << slot);
        va_vc_i    = 4'(1 << vc);
        tick();
        va_grant_i = '0;
    endtask

    task automatic sendFlits(input int n, output int cnt);
        cnt = 0;
        link_grant_i = 1'b1;
        repeat (n) begin
            tick();
            if (flit_valid_o) cnt++;
        end
        link_grant_i = 1'b0;
    endtask

    // Random legal traffic: credits only return when some are outstanding
    task automatic applyStimulus();
        pkt_valid_i = ($urandom_range(0, 1) == 1);
        setPkt(int'($urandom_range(1, MAX_PKT_FLITS)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 15)));
        va_grant_i = '0;
        va_vc_i    = 4'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 9) < 4) va_grant_i = 4'(1 << $urandom_range(0, 3));
        link_grant_i = ($urandom_range(0, 9) < 7);
        credit_in_i  = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (m_cred[v] < MAX_CREDIT && $urandom_range(0, 9) < 3) credit_in_i[v] = 1'b1;
        end
        rst = ($urandom_range(0, 599) == 0);
    endtask

    initial begin
        int cnt;
        pkt_i     = '0;
        pkt_len_i = 3'd1;
        vnet_id_i = '0;
        va_vc_i   = '0;
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_flit_valid", 64'(flit_valid_o), 64'h0);
        check("rst_free", 64'(free_slots_o), 64'h4);

        // Single 1-flit packet, vnet 1, VC 0010
        loadPkt(1, 1, 0);
        check("t1_va_req", 64'(va_req_o), 64'h1);
        check("t1_vnet", 64'(va_vnet_o[1:0]), 64'h1);
        check("t1_free", 64'(free_slots_o), 64'h3);
        vaGrant(0, 1);
        check("t1_link_req", 64'(link_req_o), 64'h1);
        link_grant_i = 1'b1;
        tick();
        link_grant_i = 1'b0;
        check("t1_valid", 64'(flit_valid_o), 64'h1);
        check("t1_vc_field", 64'(flit_o[57:56]), 64'h1);
        check("t1_payload", 64'(flit_o[7:0]), 64'h0);
        check("t1_release", 64'(release_o), 64'h2);
        check("t1_free_back", 64'(free_slots_o), 64'h4);
        tick();
        check("t1_valid_drop", 64'(flit_valid_o), 64'h0);

        // VC0 runs dry after four flits; one returned credit allows exactly one more
        doReset();
        loadPkt(4, 0, 2);
        loadPkt(2, 0, 3);
        vaGrant(0, 0);
        vaGrant(1, 0);
        sendFlits(8, cnt);
        check("t2_flits", 64'(cnt), 64'h4);
        check("t2_stalled", 64'(link_req_o), 64'h0);
        credit_in_i = 4'b0001;
        tick();
        credit_in_i = '0;
        check("t2_one_credit", 64'(link_req_o), 64'h1);
        sendFlits(3, cnt);
        check("t2_one_flit", 64'(cnt), 64'h1);
        check("t2_stalled2", 64'(link_req_o), 64'h0);

        // Two streams on VC0 and VC1 alternate under a held grant
        doReset();
        loadPkt(4, 0, 0);
        loadPkt(4, 1, 1);
        vaGrant(0, 0);
        vaGrant(1, 1);
        link_grant_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_order", 64'(flit_o[7:0]), 64'((i % 2) * 16 + i / 2));
        end
        link_grant_i = 1'b0;

        // Four back-to-back packets fill the queue; the fifth waits for a tail
        doReset();
        for (int i = 0; i < 4; i++) loadPkt(1, 0, i);
        check("t4_full_ready", 64'(pkt_ready_o), 64'h0);
        check("t4_full_free", 64'(free_slots_o), 64'h0);
        setPkt(1, 3, 9);
        pkt_valid_i = 1'b1;
        tick();
        check("t4_held", 64'(pkt_ready_o), 64'h0);
        vaGrant(2, 2);
        link_grant_i = 1'b1;
        tick();
        link_grant_i = 1'b0;
        check("t4_release", 64'(release_o), 64'h4);
        check("t4_va_req_gap", 64'(va_req_o), 64'hb);
        check("t4_ready", 64'(pkt_ready_o), 64'h1);
        tick();
        pkt_valid_i = 1'b0;
        check("t4_reload", 64'(va_req_o), 64'hf);
        check("t4_vnet", 64'(va_vnet_o[5:4]), 64'h3);

        // Credit at 1 with return and grant together keeps the counter at 1
        doReset();
        loadPkt(4, 0, 4);
        vaGrant(0, 3);
        sendFlits(3, cnt);
        check("t5_three", 64'(cnt), 64'h3);
        link_grant_i = 1'b1;
        credit_in_i  = 4'b1000;
        tick();
        link_grant_i = 1'b0;
        credit_in_i  = '0;
        check("t5_no_stall", 64'(flit_valid_o), 64'h1);
        check("t5_release", 64'(release_o), 64'h8);
        loadPkt(2, 0, 5);
        vaGrant(0, 3);
        check("t5_cred_one", 64'(link_req_o), 64'h1);
        sendFlits(3, cnt);
        check("t5_one_flit", 64'(cnt), 64'h1);
        loadPkt(3, 2, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_va", 64'(va_req_o), 64'h0);
        check("t5_rst_flit", flit_o, 64'h0);
        check("t5_rst_free", 64'(free_slots_o), 64'h4);
        loadPkt(4, 0, 7);
        vaGrant(0, 3);
        sendFlits(6, cnt);
        check("t5_full_credit", 64'(cnt), 64'h4);

`ifdef NIC_OUTQ_CREDIT_CHECK_EN
        // Excess credit on a full VC flags an error and saturates the counter
        doReset();
        check("t6_err_clear", 64'(credit_err_o), 64'h0);
        credit_in_i = 4'b0100;
        tick();
        credit_in_i = '0;
        check("t6_err_set", 64'(credit_err_o), 64'h1);
        tick();
        tick();
        check("t6_err_sticky", 64'(credit_err_o), 64'h1);
        loadPkt(4, 0, 8);
        loadPkt(4, 0, 9);
        vaGrant(0, 2);
        vaGrant(1, 2);
        sendFlits(10, cnt);
        check("t6_saturated", 64'(cnt), 64'h4);
`endif

        // Randomized traffic against the model
        doReset();
        repeat (3000) begin
            applyStimulus();
            tick();
        end
        clearInputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
